// File: rtl/writeback_unit.sv
// Write-side front end of the integer register file.
// ALU results (src0) and load/multi-cycle results (src1, buffered in a small
// FIFO) are arbitrated onto the single register-file write port.
// A per-register busy scoreboard is set at issue and cleared at commit so
// that decode can stall on RAW and WAW hazards.
module writeback_unit #(
    parameter int WIDTH      = 32,
    parameter int REGS       = 32,
    parameter int FIFO_DEPTH = 2,
    localparam int AW        = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src0_valid,
    input  logic [AW-1:0]    src0_rd,
    input  logic [WIDTH-1:0] src0_data,
    output logic             src0_ready,
    input  logic             src1_valid,
    input  logic [AW-1:0]    src1_rd,
    input  logic [WIDTH-1:0] src1_data,
    output logic             src1_ready,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ready,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic             hazard_stall,
    output logic             rf_we,
    output logic [AW-1:0]    rf_addr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [REGS-1:0]  busy
);

    localparam int PW = $clog2(FIFO_DEPTH);

    // x0 is hardwired to zero: a commit to it is consumed but never written.
    function automatic logic writes_rf(input logic vld, input logic [AW-1:0] rd);
        return vld && (rd != '0);
    endfunction

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [AW-1:0]    fifo_rd_mem   [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             src0_xfer;

    logic             commit_vld_p0;
    logic [AW-1:0]    commit_rd_p0;
    logic [WIDTH-1:0] commit_data_p0;

    logic             issue_set;
    logic [REGS-1:0]  busy_nxt;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    // Both readies depend only on registered occupancy, never on this cycle's pop.
    assign src0_ready = ~fifo_full;
    assign src1_ready = ~fifo_full;

    assign src0_xfer = src0_valid & src0_ready;
    assign push      = src1_valid & src1_ready;

    // Arbitration: a full FIFO drains first, then src0, then any FIFO backlog.
    always_comb begin
        pop            = 1'b0;
        commit_vld_p0  = 1'b0;
        commit_rd_p0   = src0_rd;
        commit_data_p0 = src0_data;
        if (fifo_full) begin
            pop            = 1'b1;
            commit_vld_p0  = 1'b1;
            commit_rd_p0   = fifo_rd_mem[rd_ptr[PW-1:0]];
            commit_data_p0 = fifo_data_mem[rd_ptr[PW-1:0]];
        end else if (src0_xfer) begin
            commit_vld_p0  = 1'b1;
        end else if (!fifo_empty) begin
            pop            = 1'b1;
            commit_vld_p0  = 1'b1;
            commit_rd_p0   = fifo_rd_mem[rd_ptr[PW-1:0]];
            commit_data_p0 = fifo_data_mem[rd_ptr[PW-1:0]];
        end
    end

    // FIFO pointer update; reset empties the buffer and discards its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // FIFO storage; entries are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr[PW-1:0]]   <= src1_rd;
            fifo_data_mem[wr_ptr[PW-1:0]] <= src1_data;
        end
    end

    // ---- commit stage: p0 selection -> registered register-file write port ----
    // Idle cycles drop the enable but keep the last address and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= writes_rf(commit_vld_p0, commit_rd_p0);
            if (commit_vld_p0) begin
                rf_addr  <= commit_rd_p0;
                rf_wdata <= commit_data_p0;
            end
        end
    end

    assign issue_ready = (issue_rd == '0) | ~busy[issue_rd];
    assign issue_set   = writes_rf(issue_valid & issue_ready, issue_rd);

    // Scoreboard next state: clear on the edge the register file stores, set
    // afterwards so a same-edge issue to the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (rf_we)     busy_nxt[rf_addr]  = 1'b0;
        if (issue_set) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign hazard_stall = ((rs1 != '0) & busy[rs1]) | ((rs2 != '0) & busy[rs2]);

endmodule
